darkbus_arbiter: RTL and testbench

//  Shares one downstream device_bus (on-chip ROM/RAM/IO) between two requesters:
//  the core's instruction-fetch port (I) and its load/store port (D).

---
 rtl/darkarb_pkg.sv | 21 ++
 rtl/darkbus_arbiter_if.sv | 23 ++
 rtl/darkarb_rr.sv | 28 ++
 rtl/darkbus_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_darkbus_arbiter.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/darkarb_pkg.sv
// darkarb_pkg
// Shared types and constants for the darkbus arbiter.
//   arb_state_t : transaction FSM state (IDLE -> BUSY -> DONE -> IDLE)
//   arb_owner_t : which requester holds the device bus (fetch I or load/store D)
//   NOP_INSN    : value presented on RDATA after reset and after an aborted read
package darkarb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage : darkarb_pkg

// File: rtl/darkbus_arbiter_if.sv
// device_bus
// Downstream device bus shared by ROM/RAM/IO.
//   ADDR  32  byte address (producer)
//   DATA  32  bidirectional data: producer drives write data, device drives read data
//   EN        transaction enable (producer)
//   RE/WE     read / write strobe (producer)
//   RACK      read acknowledge, DATA valid in the same cycle (device)
//   WACK      write acknowledge (device)
// Modports: prod/master = arbiter side, cons/slave = device side.
interface device_bus;
    logic [31:0] ADDR;
    wire  [31:0] DATA;
    logic        EN;
    logic        RE;
    logic        WE;
    logic        RACK;
    logic        WACK;

    modport prod   (output ADDR, EN, RE, WE, inout DATA, input RACK, WACK);
    modport master (output ADDR, EN, RE, WE, inout DATA, input RACK, WACK);
    modport cons   (input ADDR, EN, RE, WE, inout DATA, output RACK, WACK);
    modport slave  (input ADDR, EN, RE, WE, inout DATA, output RACK, WACK);
endinterface : device_bus

// File: rtl/darkarb_rr.sv
// darkarb_rr
// Combinational two-way round-robin picker.
//   i_req          fetch port requesting
//   d_req          load/store port requesting
//   i_last         owner granted most recently
//   o_grant_valid  at least one request present
//   o_grant_owner  winner; on a tie the port NOT granted last wins
module darkarb_rr
    import darkarb_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  arb_owner_t i_last,
    output logic       o_grant_valid,
    output arb_owner_t o_grant_owner
);

    always_comb begin
        o_grant_valid = i_req | d_req;
        o_grant_owner = OWN_I;
        if (i_req && d_req) begin
            o_grant_owner = (i_last == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            o_grant_owner = OWN_D;
        end
    end

endmodule : darkarb_rr

// File: rtl/darkbus_arbiter.sv
// darkbus_arbiter
// Shares one device_bus between the core fetch port (I) and load/store port (D).
// Round-robin grant, one outstanding transaction; owner held until device ack.
// Optional feature macro: DARKARB_TIMEOUT_EN (BUSY abort after TIMEOUT cycles).
// Parameters:
//   TIMEOUT  BUSY cycles without ack before abort (1..255, timeout build only)
//   D_FIRST  1 = D wins the first tie after reset, 0 = I wins
// Ports:
//   XCLK, XRES                 clock, async active-low reset
//   I_REQ/I_ADDR               fetch request, held until I_ACK
//   I_RDATA/I_ACK              fetch data, one-cycle completion pulse
//   D_REQ/D_WE/D_ADDR/D_WDATA  load/store request, held until D_ACK
//   D_RDATA/D_ACK              read data, one-cycle completion pulse
//   ERR                        with ACK: transaction aborted by timeout
//   DEV                        device_bus producer side
//
// state | meaning
// IDLE  | bus idle, requests sampled, grant on any request
// BUSY  | DEV.EN high, waiting for RACK/WACK (or timeout)
// DONE  | owner ACK pulse, bus released, last-owner updated
module darkbus_arbiter
    import darkarb_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter bit D_FIRST = 1'b1
) (
    input  logic        XCLK,
    input  logic        XRES,
    input  logic        I_REQ,
    input  logic [31:0] I_ADDR,
    output logic [31:0] I_RDATA,
    output logic        I_ACK,
    input  logic        D_REQ,
    input  logic        D_WE,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_WDATA,
    output logic [31:0] D_RDATA,
    output logic        D_ACK,
    output logic        ERR,
    device_bus.prod     DEV
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("darkbus_arbiter: TIMEOUT must be in 1..255");
    end

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;
    arb_owner_t  r_owner;
    arb_owner_t  r_last;
    logic [31:0] r_addr;
    logic        r_we;
    logic [31:0] r_wdata;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;

    logic        w_grant_valid;
    arb_owner_t  w_grant_owner;
    logic        w_dev_ack;
    logic        w_timeout;
    logic        w_data_oe;
    logic        w_err;

    darkarb_rr u_rr (
        .i_req         (I_REQ),
        .d_req         (D_REQ),
        .i_last        (r_last),
        .o_grant_valid (w_grant_valid),
        .o_grant_owner (w_grant_owner)
    );

    // Only the strobe matching the latched direction counts as completion.
    assign w_dev_ack = (!r_we && DEV.RACK) || (r_we && DEV.WACK);

`ifdef DARKARB_TIMEOUT_EN
    localparam logic [7:0] TO8 = 8'(TIMEOUT);

    logic [7:0] r_tcnt;
    logic       r_err;

    // Fires in the BUSY cycle whose increment would reach TIMEOUT, so BUSY
    // lasts exactly TIMEOUT cycles when the device stays silent.
    assign w_timeout = (r_state == BUSY) && ((r_tcnt + 8'd1) == TO8);
    assign w_err     = r_err;

    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            r_tcnt <= 8'd0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                BUSY: begin
                    r_tcnt <= r_tcnt + 8'd1;
                    // ack in the same cycle as the timeout wins
                    r_err  <= w_timeout && !w_dev_ack;
                end
                DONE: begin
                    r_tcnt <= 8'd0;
                    r_err  <= r_err;
                end
                default: begin
                    r_tcnt <= 8'd0;
                    r_err  <= 1'b0;
                end
            endcase
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_err     = 1'b0;
`endif

    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant_valid) w_state_nxt = BUSY;
            BUSY:    if (w_dev_ack || w_timeout) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        DEV.EN    = 1'b0;
        DEV.RE    = 1'b0;
        DEV.WE    = 1'b0;
        DEV.ADDR  = 32'h0;
        w_data_oe = 1'b0;
        I_ACK     = 1'b0;
        D_ACK     = 1'b0;
        ERR       = 1'b0;
        case (r_state)
            BUSY: begin
                DEV.EN    = 1'b1;
                DEV.ADDR  = r_addr;
                DEV.RE    = !r_we;
                DEV.WE    = r_we;
                w_data_oe = r_we;
            end
            DONE: begin
                I_ACK = (r_owner == OWN_I);
                D_ACK = (r_owner == OWN_D);
                ERR   = w_err;
            end
            default: ;
        endcase
    end

    assign DEV.DATA = w_data_oe ? r_wdata : 32'hzzzz_zzzz;
    assign I_RDATA  = r_i_rdata;
    assign D_RDATA  = r_d_rdata;

    // Datapath: request latched at grant, read data captured at device ack.
    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            r_owner   <= OWN_I;
            r_last    <= D_FIRST ? OWN_I : OWN_D;
            r_addr    <= 32'h0;
            r_we      <= 1'b0;
            r_wdata   <= 32'h0;
            r_i_rdata <= NOP_INSN;
            r_d_rdata <= NOP_INSN;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_owner <= w_grant_owner;
                        if (w_grant_owner == OWN_D) begin
                            r_addr  <= D_ADDR;
                            r_we    <= D_WE;
                            r_wdata <= D_WDATA;
                        end else begin
                            r_addr  <= I_ADDR;
                            r_we    <= 1'b0;
                            r_wdata <= 32'h0;
                        end
                    end
                end
                BUSY: begin
                    if (w_dev_ack) begin
                        if (!r_we) begin
                            if (r_owner == OWN_I) r_i_rdata <= DEV.DATA;
                            else                  r_d_rdata <= DEV.DATA;
                        end
                    end else if (w_timeout) begin
                        if (r_owner == OWN_I) r_i_rdata <= NOP_INSN;
                        else                  r_d_rdata <= NOP_INSN;
                    end
                end
                DONE: begin
                    r_last <= r_owner;
                end
                default: ;
            endcase
        end
    end

endmodule : darkbus_arbiter

// File: tb/tb_darkbus_arbiter.sv
module tb_darkbus_arbiter;
    import darkarb_pkg::*;

    logic        XCLK = 1'b0;
    logic        XRES = 1'b0;
    logic        I_REQ = 1'b0;
    logic [31:0] I_ADDR = 32'h0;
    logic [31:0] I_RDATA;
    logic        I_ACK;
    logic        D_REQ = 1'b0;
    logic        D_WE = 1'b0;
    logic [31:0] D_ADDR = 32'h0;
    logic [31:0] D_WDATA = 32'h0;
    logic [31:0] D_RDATA;
    logic        D_ACK;
    logic        ERR;

    int total = 0;
    int bad   = 0;

    device_bus bus ();

    darkbus_arbiter #(.TIMEOUT(15), .D_FIRST(1'b1)) dut (
        .XCLK    (XCLK),
        .XRES    (XRES),
        .I_REQ   (I_REQ),
        .I_ADDR  (I_ADDR),
        .I_RDATA (I_RDATA),
        .I_ACK   (I_ACK),
        .D_REQ   (D_REQ),
        .D_WE    (D_WE),
        .D_ADDR  (D_ADDR),
        .D_WDATA (D_WDATA),
        .D_RDATA (D_RDATA),
        .D_ACK   (D_ACK),
        .ERR     (ERR),
        .DEV     (bus)
    );

    always #5 XCLK = ~XCLK;

    // Device model: registered one-cycle ack, second cycle of EN.
    logic        dev_rack = 1'b0;
    logic        dev_wack = 1'b0;
    logic        dev_hang = 1'b0;
    logic [31:0] dev_waddr = 32'h0;
    logic [31:0] dev_wdata = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_0000);
    endfunction

    always @(posedge XCLK) begin
        dev_rack <= bus.EN && bus.RE && !dev_rack && !dev_hang;
        dev_wack <= bus.EN && bus.WE && !dev_wack && !dev_hang;
        if (dev_wack) begin
            dev_waddr <= bus.ADDR;
            dev_wdata <= bus.DATA;
        end
    end

    assign bus.RACK = dev_rack;
    assign bus.WACK = dev_wack;
    assign bus.DATA = dev_rack ? mem_word(bus.ADDR) : 32'hzzzz_zzzz;

    task automatic step();
        @(posedge XCLK);
        #1;
    endtask

    task automatic do_reset();
        I_REQ = 1'b0; D_REQ = 1'b0; D_WE = 1'b0;
        I_ADDR = 32'h0; D_ADDR = 32'h0; D_WDATA = 32'h0;
        dev_hang = 1'b0;
        XRES = 1'b0;
        step(); step();
        XRES = 1'b1;
        step();
    endtask

    task automatic test_reset();
        XRES = 1'b0;
        step(); step();
        total++;
        if (bus.EN !== 1'b0 || bus.RE !== 1'b0 || bus.WE !== 1'b0) begin
            bad++; $display("FAIL reset_strobes: got EN=%b RE=%b WE=%b exp 0 0 0", bus.EN, bus.RE, bus.WE);
        end
        total++;
        if (I_ACK !== 1'b0 || D_ACK !== 1'b0 || ERR !== 1'b0) begin
            bad++; $display("FAIL reset_acks: got I_ACK=%b D_ACK=%b ERR=%b exp 0 0 0", I_ACK, D_ACK, ERR);
        end
        total++;
        if (I_RDATA !== 32'h0000_0013 || D_RDATA !== 32'h0000_0013) begin
            bad++; $display("FAIL reset_rdata: got %h %h exp 00000013", I_RDATA, D_RDATA);
        end
        XRES = 1'b1;
        step();
    endtask

    task automatic test_fetch();
        do_reset();
        I_ADDR = 32'h10; I_REQ = 1'b1;
        step();
        total++;
        if (bus.EN !== 1'b1 || bus.RE !== 1'b1 || bus.ADDR !== 32'h10 || I_ACK !== 1'b0) begin
            bad++; $display("FAIL fetch_c1: got EN=%b RE=%b ADDR=%h ACK=%b exp 1 1 00000010 0", bus.EN, bus.RE, bus.ADDR, I_ACK);
        end
        step();
        total++;
        if (bus.EN !== 1'b1 || I_ACK !== 1'b0) begin
            bad++; $display("FAIL fetch_c2: got EN=%b ACK=%b exp 1 0", bus.EN, I_ACK);
        end
        step();
        total++;
        if (I_ACK !== 1'b1 || D_ACK !== 1'b0 || ERR !== 1'b0 || bus.EN !== 1'b0) begin
            bad++; $display("FAIL fetch_c3: got I_ACK=%b D_ACK=%b ERR=%b EN=%b exp 1 0 0 0", I_ACK, D_ACK, ERR, bus.EN);
        end
        total++;
        if (I_RDATA !== 32'hDEAD_BEEF || D_RDATA !== 32'h0000_0013) begin
            bad++; $display("FAIL fetch_data: got I=%h D=%h exp deadbeef 00000013", I_RDATA, D_RDATA);
        end
        I_REQ = 1'b0;
        step();
        total++;
        if (I_ACK !== 1'b0) begin
            bad++; $display("FAIL fetch_pulse: got I_ACK=%b exp 0", I_ACK);
        end
    endtask

    task automatic test_alternate();
        logic exp_d [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int n = 0;
        do_reset();
        I_ADDR = 32'h30; D_ADDR = 32'h20; D_WE = 1'b0;
        I_REQ = 1'b1; D_REQ = 1'b1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            step();
            if (I_ACK || D_ACK) begin
                total++;
                if (D_ACK !== exp_d[n] || I_ACK !== !exp_d[n]) begin
                    bad++; $display("FAIL alt_order[%0d]: got D_ACK=%b I_ACK=%b exp D_ACK=%b", n, D_ACK, I_ACK, exp_d[n]);
                end
                total++;
                if (D_ACK && D_RDATA !== mem_word(32'h20) || I_ACK && I_RDATA !== mem_word(32'h30)) begin
                    bad++; $display("FAIL alt_data[%0d]: got D=%h I=%h exp D=%h I=%h", n, D_RDATA, I_RDATA, mem_word(32'h20), mem_word(32'h30));
                end
                n++;
            end
        end
        total++;
        if (n != 4) begin
            bad++; $display("FAIL alt_count: got %0d acks exp 4", n);
        end
        I_REQ = 1'b0; D_REQ = 1'b0;
    endtask

    task automatic test_write();
        do_reset();
        D_ADDR = 32'h8000_0004; D_WDATA = 32'h1234_5678; D_WE = 1'b1; D_REQ = 1'b1;
        step();
        total++;
        if (bus.EN !== 1'b1 || bus.WE !== 1'b1 || bus.RE !== 1'b0 || bus.DATA !== 32'h1234_5678 || bus.ADDR !== 32'h8000_0004) begin
            bad++; $display("FAIL wr_c1: got EN=%b WE=%b RE=%b DATA=%h ADDR=%h exp 1 1 0 12345678 80000004", bus.EN, bus.WE, bus.RE, bus.DATA, bus.ADDR);
        end
        step();
        total++;
        if (bus.WE !== 1'b1 || bus.DATA !== 32'h1234_5678 || D_ACK !== 1'b0) begin
            bad++; $display("FAIL wr_c2: got WE=%b DATA=%h ACK=%b exp 1 12345678 0", bus.WE, bus.DATA, D_ACK);
        end
        step();
        total++;
        if (D_ACK !== 1'b1 || I_ACK !== 1'b0 || bus.WE !== 1'b0 || bus.EN !== 1'b0 || dut.w_data_oe !== 1'b0) begin
            bad++; $display("FAIL wr_c3: got D_ACK=%b I_ACK=%b WE=%b EN=%b OE=%b exp 1 0 0 0 0", D_ACK, I_ACK, bus.WE, bus.EN, dut.w_data_oe);
        end
        total++;
        if (dev_waddr !== 32'h8000_0004 || dev_wdata !== 32'h1234_5678 || D_RDATA !== 32'h0000_0013) begin
            bad++; $display("FAIL wr_mem: got addr=%h data=%h rdata=%h exp 80000004 12345678 00000013", dev_waddr, dev_wdata, D_RDATA);
        end
        D_REQ = 1'b0; D_WE = 1'b0;
        step();
        total++;
        if (D_ACK !== 1'b0) begin
            bad++; $display("FAIL wr_pulse: got D_ACK=%b exp 0", D_ACK);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        I_ADDR = 32'h10; I_REQ = 1'b1;
        step();
        #2 XRES = 1'b0;
        #1;
        total++;
        if (bus.EN !== 1'b0) begin
            bad++; $display("FAIL mrst_en: got EN=%b exp 0", bus.EN);
        end
        step(); step();
        total++;
        if (I_ACK !== 1'b0 || D_ACK !== 1'b0) begin
            bad++; $display("FAIL mrst_noack: got I_ACK=%b D_ACK=%b exp 0 0", I_ACK, D_ACK);
        end
        XRES = 1'b1;
        step();
        total++;
        if (bus.EN !== 1'b1) begin
            bad++; $display("FAIL mrst_c1: got EN=%b exp 1", bus.EN);
        end
        step(); step();
        total++;
        if (I_ACK !== 1'b1 || I_RDATA !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL mrst_c3: got ACK=%b RDATA=%h exp 1 deadbeef", I_ACK, I_RDATA);
        end
        I_REQ = 1'b0;
        step();
    endtask

    task automatic test_addr_latch();
        do_reset();
        D_ADDR = 32'h40; D_WE = 1'b0; D_REQ = 1'b1;
        step();
        D_ADDR = 32'h44;
        #1;
        total++;
        if (bus.ADDR !== 32'h40) begin
            bad++; $display("FAIL latch_c1: got ADDR=%h exp 00000040", bus.ADDR);
        end
        step();
        total++;
        if (bus.ADDR !== 32'h40) begin
            bad++; $display("FAIL latch_c2: got ADDR=%h exp 00000040", bus.ADDR);
        end
        step();
        total++;
        if (D_ACK !== 1'b1 || D_RDATA !== mem_word(32'h40)) begin
            bad++; $display("FAIL latch_data: got ACK=%b RDATA=%h exp 1 %h", D_ACK, D_RDATA, mem_word(32'h40));
        end
        D_REQ = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int c = 0;
        do_reset();
        I_ADDR = 32'h10; I_REQ = 1'b1;
        while (I_ACK !== 1'b1 && c < 10) begin
            step(); c++;
        end
        I_REQ = 1'b0;
        step();
        total++;
        if (I_RDATA !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL to_pre: got %h exp deadbeef", I_RDATA);
        end
        dev_hang = 1'b1;
        I_ADDR = 32'h50; I_REQ = 1'b1;
        step();
`ifdef DARKARB_TIMEOUT_EN
        repeat (14) step();
        total++;
        if (bus.EN !== 1'b1 || I_ACK !== 1'b0) begin
            bad++; $display("FAIL to_c15: got EN=%b ACK=%b exp 1 0", bus.EN, I_ACK);
        end
        step();
        total++;
        if (I_ACK !== 1'b1 || ERR !== 1'b1 || I_RDATA !== 32'h0000_0013 || bus.EN !== 1'b0) begin
            bad++; $display("FAIL to_abort: got ACK=%b ERR=%b RDATA=%h EN=%b exp 1 1 00000013 0", I_ACK, ERR, I_RDATA, bus.EN);
        end
`else
        c = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (I_ACK !== 1'b0 || ERR !== 1'b0 || bus.EN !== 1'b1) c++;
        end
        total++;
        if (c != 0) begin
            bad++; $display("FAIL hang_wait: got %0d cycles with ack/err/!EN exp 0", c);
        end
`endif
        I_REQ = 1'b0;
        dev_hang = 1'b0;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_alternate();
        test_write();
        test_mid_reset();
        test_addr_latch();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_darkbus_arbiter
